// File: rtl/lsu_pkg.sv
// Shared encodings and request/in-flight record types for the LSU scheduler.
package lsu_pkg;

  localparam logic WIDTH_16   = 1'b0;
  localparam logic WIDTH_8    = 1'b1;
  localparam logic CMD_READ   = 1'b0;
  localparam logic CMD_WRITE  = 1'b1;
  localparam logic PORT_DATA  = 1'b0;
  localparam logic PORT_FETCH = 1'b1;
  localparam logic [1:0] FETCH_TAG = 2'b00;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SPLIT2 = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        width;
    logic        cmd;
    logic [1:0]  tag;
  } req_t;

  typedef struct packed {
    logic       valid;
    logic       port;
    logic [1:0] tag;
    logic       last;
  } inflight_t;

  // A 16-bit access on an odd address cannot go out as one bus beat.
  function automatic logic needs_split(input req_t r);
    return (r.width == WIDTH_16) && r.addr[0];
  endfunction

endpackage

// File: rtl/lsu_sched_if.sv
// Request, LSU and completion signals of the scheduler; master = requesters/LSU side.
interface lsu_sched_if;

  logic [15:0] d_addr;
  logic [15:0] d_data;
  logic        d_width;
  logic        d_cmd;
  logic [1:0]  d_tag;
  logic        d_valid;
  logic        d_ready;

  logic [15:0] f_addr;
  logic        f_valid;
  logic        f_ready;

  logic [15:0] lsu_addr;
  logic [15:0] lsu_data;
  logic        lsu_width;
  logic        lsu_cmd;
  logic [1:0]  lsu_tag;
  logic        lsu_start;
  logic        lsu_hold;

  logic        mem_rdy;

  logic        cpl_valid;
  logic        cpl_port;
  logic [1:0]  cpl_tag;
  logic        cpl_last;

  modport master (
    output d_addr, d_data, d_width, d_cmd, d_tag, d_valid, f_addr, f_valid,
           lsu_hold, mem_rdy,
    input  d_ready, f_ready, lsu_addr, lsu_data, lsu_width, lsu_cmd, lsu_tag,
           lsu_start, cpl_valid, cpl_port, cpl_tag, cpl_last
  );

  modport slave (
    input  d_addr, d_data, d_width, d_cmd, d_tag, d_valid, f_addr, f_valid,
           lsu_hold, mem_rdy,
    output d_ready, f_ready, lsu_addr, lsu_data, lsu_width, lsu_cmd, lsu_tag,
           lsu_start, cpl_valid, cpl_port, cpl_tag, cpl_last
  );

endinterface

// File: rtl/lsu_sched_slot.sv
// One-entry request slot that splits odd 16-bit accesses into two byte parts.
// Ready is registered (empty slot); slot holds until its final part issues.
module lsu_sched_slot
  import lsu_pkg::*;
(
  input  logic       clk,
  input  logic       a_rst,
  input  req_t       in_req_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       issue_i,
  output logic       full_o,
  output req_t       part_o,
  output logic       last_o,
  output seq_state_t state_o
);

  logic       full_q, full_d;
  req_t       req_q, req_d;
  seq_state_t state_q, state_d;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      full_q  <= 1'b0;
      req_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      full_q  <= full_d;
      req_q   <= req_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    part_o = req_q;
    last_o = 1'b1;
    if (state_q == ST_SPLIT2) begin
      part_o.addr  = req_q.addr + 16'd1;
      part_o.data  = {2{req_q.data[15:8]}};
      part_o.width = WIDTH_8;
    end else if (needs_split(req_q)) begin
      part_o.data  = {2{req_q.data[7:0]}};
      part_o.width = WIDTH_8;
      last_o       = 1'b0;
    end
  end

  always_comb begin
    full_d  = full_q;
    req_d   = req_q;
    state_d = state_q;
    if (in_valid_i && !full_q) begin
      full_d = 1'b1;
      req_d  = in_req_i;
    end
    if (issue_i) begin
      if (last_o) begin
        full_d  = 1'b0;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_SPLIT2;
      end
    end
  end

  assign in_ready_o = !full_q;
  assign full_o     = full_q;
  assign state_o    = state_q;

endmodule

// File: rtl/lsu_sched.sv
// Round-robin scheduler of data and fetch requests onto one LSU; issue >= 1 cycle after accept.
// lsu_hold stalls the selected part; a port's ready stays low until its final part issues.
module lsu_sched
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        a_rst,
  lsu_sched_if.slave  bus
);

  req_t       d_req, f_req, d_part, f_part, part;
  logic       d_full, f_full, d_last, f_last, last;
  logic       d_issue, f_issue, issue, start, sel;
  seq_state_t d_state, f_state;
  logic       rr_q, rr_d;
  inflight_t  infl_q, infl_d;

  assign d_req = '{addr: bus.d_addr, data: bus.d_data, width: bus.d_width,
                   cmd: bus.d_cmd, tag: bus.d_tag};
  assign f_req = '{addr: bus.f_addr, data: 16'h0000, width: WIDTH_16,
                   cmd: CMD_READ, tag: FETCH_TAG};

  lsu_sched_slot u_dslot (
    .clk(clk), .a_rst(a_rst), .in_req_i(d_req), .in_valid_i(bus.d_valid),
    .in_ready_o(bus.d_ready), .issue_i(d_issue), .full_o(d_full),
    .part_o(d_part), .last_o(d_last), .state_o(d_state)
  );

  lsu_sched_slot u_fslot (
    .clk(clk), .a_rst(a_rst), .in_req_i(f_req), .in_valid_i(bus.f_valid),
    .in_ready_o(bus.f_ready), .issue_i(f_issue), .full_o(f_full),
    .part_o(f_part), .last_o(f_last), .state_o(f_state)
  );

  // A port with part 2 pending keeps the bus regardless of rr.
  always_comb begin
    sel = rr_q;
    if (d_state == ST_SPLIT2)     sel = PORT_DATA;
    else if (f_state == ST_SPLIT2) sel = PORT_FETCH;
    else if (d_full && !f_full)    sel = PORT_DATA;
    else if (f_full && !d_full)    sel = PORT_FETCH;
  end

  assign start   = d_full || f_full;
  assign issue   = start && !bus.lsu_hold;
  assign part    = (sel == PORT_FETCH) ? f_part : d_part;
  assign last    = (sel == PORT_FETCH) ? f_last : d_last;
  assign d_issue = issue && (sel == PORT_DATA);
  assign f_issue = issue && (sel == PORT_FETCH);

  always_comb begin
    rr_d   = rr_q;
    infl_d = infl_q;
    if (issue && last) rr_d = (sel == PORT_DATA) ? PORT_FETCH : PORT_DATA;
    if (issue) begin
      infl_d = '{valid: 1'b1, port: sel, tag: part.tag, last: last};
    end else if (bus.mem_rdy) begin
      infl_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      rr_q   <= PORT_DATA;
      infl_q <= '0;
    end else begin
      rr_q   <= rr_d;
      infl_q <= infl_d;
    end
  end

  assign bus.lsu_addr  = part.addr;
  assign bus.lsu_data  = part.data;
  assign bus.lsu_width = part.width;
  assign bus.lsu_cmd   = part.cmd;
  assign bus.lsu_tag   = part.tag;
  assign bus.lsu_start = start;

  assign bus.cpl_valid = bus.mem_rdy && infl_q.valid;
  assign bus.cpl_port  = infl_q.port;
  assign bus.cpl_tag   = infl_q.tag;
  assign bus.cpl_last  = infl_q.last;

endmodule

// File: tb/tb_lsu_sched.sv
// Directed-vector bench for lsu_sched.
module tb_lsu_sched;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic a_rst;
  int   checks = 0;
  int   errors = 0;

  lsu_sched_if bus ();

  lsu_sched dut (.clk(clk), .a_rst(a_rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b0;
    bus.d_valid = 1'b1; bus.f_valid = 1'b1; bus.mem_rdy = 1'b1; bus.lsu_hold = 1'b0;
    tick(); tick();
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL rst_d_ready: got %b exp 1", bus.d_ready); end
    checks++; if (bus.f_ready !== 1'b1) begin errors++; $display("FAIL rst_f_ready: got %b exp 1", bus.f_ready); end
    checks++; if (bus.lsu_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b exp 0", bus.lsu_start); end
    checks++; if (bus.cpl_valid !== 1'b0) begin errors++; $display("FAIL rst_cpl_valid: got %b exp 0", bus.cpl_valid); end
    bus.d_valid = 1'b0; bus.f_valid = 1'b0; bus.mem_rdy = 1'b0;
    #1 a_rst = 1'b1;
    tick();
    checks++; if (bus.lsu_start !== 1'b0) begin errors++; $display("FAIL rst_release_start: got %b exp 0", bus.lsu_start); end
  endtask

  task automatic test_aligned();
    tick();
    bus.d_addr = 16'h1000; bus.d_data = 16'hBEEF; bus.d_width = WIDTH_16;
    bus.d_cmd = CMD_WRITE; bus.d_tag = 2'd2; bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0; settle();
    checks++; if (bus.lsu_start !== 1'b1) begin errors++; $display("FAIL al_start: got %b exp 1", bus.lsu_start); end
    checks++; if (bus.lsu_addr !== 16'h1000) begin errors++; $display("FAIL al_addr: got %h exp 1000", bus.lsu_addr); end
    checks++; if (bus.lsu_data !== 16'hBEEF) begin errors++; $display("FAIL al_data: got %h exp beef", bus.lsu_data); end
    checks++; if (bus.lsu_width !== WIDTH_16) begin errors++; $display("FAIL al_width: got %b exp 0", bus.lsu_width); end
    checks++; if (bus.lsu_cmd !== CMD_WRITE) begin errors++; $display("FAIL al_cmd: got %b exp 1", bus.lsu_cmd); end
    checks++; if (bus.lsu_tag !== 2'd2) begin errors++; $display("FAIL al_tag: got %0d exp 2", bus.lsu_tag); end
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL al_d_ready_full: got %b exp 0", bus.d_ready); end
    tick();
    bus.mem_rdy = 1'b1; settle();
    checks++; if (bus.lsu_start !== 1'b0) begin errors++; $display("FAIL al_start_after: got %b exp 0", bus.lsu_start); end
    checks++; if (bus.cpl_valid !== 1'b1) begin errors++; $display("FAIL al_cpl_valid: got %b exp 1", bus.cpl_valid); end
    checks++; if (bus.cpl_port !== PORT_DATA) begin errors++; $display("FAIL al_cpl_port: got %b exp 0", bus.cpl_port); end
    checks++; if (bus.cpl_tag !== 2'd2) begin errors++; $display("FAIL al_cpl_tag: got %0d exp 2", bus.cpl_tag); end
    checks++; if (bus.cpl_last !== 1'b1) begin errors++; $display("FAIL al_cpl_last: got %b exp 1", bus.cpl_last); end
    tick(); settle();
    checks++; if (bus.cpl_valid !== 1'b0) begin errors++; $display("FAIL al_cpl_cleared: got %b exp 0", bus.cpl_valid); end
    bus.mem_rdy = 1'b0;
  endtask

  task automatic test_unaligned();
    tick();
    bus.d_addr = 16'h2001; bus.d_data = 16'h1234; bus.d_width = WIDTH_16;
    bus.d_cmd = CMD_WRITE; bus.d_tag = 2'd1; bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0; settle();
    checks++; if (bus.lsu_start !== 1'b1) begin errors++; $display("FAIL ua_p1_start: got %b exp 1", bus.lsu_start); end
    checks++; if (bus.lsu_addr !== 16'h2001) begin errors++; $display("FAIL ua_p1_addr: got %h exp 2001", bus.lsu_addr); end
    checks++; if (bus.lsu_data !== 16'h3434) begin errors++; $display("FAIL ua_p1_data: got %h exp 3434", bus.lsu_data); end
    checks++; if (bus.lsu_width !== WIDTH_8) begin errors++; $display("FAIL ua_p1_width: got %b exp 1", bus.lsu_width); end
    checks++; if (bus.lsu_tag !== 2'd1) begin errors++; $display("FAIL ua_p1_tag: got %0d exp 1", bus.lsu_tag); end
    tick();
    bus.mem_rdy = 1'b1; settle();
    checks++; if (bus.lsu_start !== 1'b1) begin errors++; $display("FAIL ua_p2_start: got %b exp 1", bus.lsu_start); end
    checks++; if (bus.lsu_addr !== 16'h2002) begin errors++; $display("FAIL ua_p2_addr: got %h exp 2002", bus.lsu_addr); end
    checks++; if (bus.lsu_data !== 16'h1212) begin errors++; $display("FAIL ua_p2_data: got %h exp 1212", bus.lsu_data); end
    checks++; if (bus.lsu_width !== WIDTH_8) begin errors++; $display("FAIL ua_p2_width: got %b exp 1", bus.lsu_width); end
    checks++; if (bus.lsu_cmd !== CMD_WRITE) begin errors++; $display("FAIL ua_p2_cmd: got %b exp 1", bus.lsu_cmd); end
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL ua_mid_ready: got %b exp 0", bus.d_ready); end
    checks++; if (bus.cpl_valid !== 1'b1) begin errors++; $display("FAIL ua_c1_valid: got %b exp 1", bus.cpl_valid); end
    checks++; if (bus.cpl_last !== 1'b0) begin errors++; $display("FAIL ua_c1_last: got %b exp 0", bus.cpl_last); end
    checks++; if (bus.cpl_tag !== 2'd1) begin errors++; $display("FAIL ua_c1_tag: got %0d exp 1", bus.cpl_tag); end
    tick(); settle();
    checks++; if (bus.lsu_start !== 1'b0) begin errors++; $display("FAIL ua_done_start: got %b exp 0", bus.lsu_start); end
    checks++; if (bus.cpl_valid !== 1'b1) begin errors++; $display("FAIL ua_c2_valid: got %b exp 1", bus.cpl_valid); end
    checks++; if (bus.cpl_last !== 1'b1) begin errors++; $display("FAIL ua_c2_last: got %b exp 1", bus.cpl_last); end
    checks++; if (bus.cpl_port !== PORT_DATA) begin errors++; $display("FAIL ua_c2_port: got %b exp 0", bus.cpl_port); end
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL ua_done_ready: got %b exp 1", bus.d_ready); end
    tick();
    bus.mem_rdy = 1'b0;
  endtask

  task automatic test_wrap();
    tick();
    bus.f_addr = 16'hFFFF; bus.f_valid = 1'b1;
    tick();
    bus.f_valid = 1'b0; settle();
    checks++; if (bus.lsu_start !== 1'b1) begin errors++; $display("FAIL wr_p1_start: got %b exp 1", bus.lsu_start); end
    checks++; if (bus.lsu_addr !== 16'hFFFF) begin errors++; $display("FAIL wr_p1_addr: got %h exp ffff", bus.lsu_addr); end
    checks++; if (bus.lsu_width !== WIDTH_8) begin errors++; $display("FAIL wr_p1_width: got %b exp 1", bus.lsu_width); end
    checks++; if (bus.lsu_cmd !== CMD_READ) begin errors++; $display("FAIL wr_p1_cmd: got %b exp 0", bus.lsu_cmd); end
    checks++; if (bus.lsu_tag !== FETCH_TAG) begin errors++; $display("FAIL wr_p1_tag: got %0d exp 0", bus.lsu_tag); end
    tick();
    bus.mem_rdy = 1'b1; settle();
    checks++; if (bus.lsu_addr !== 16'h0000) begin errors++; $display("FAIL wr_p2_addr: got %h exp 0000", bus.lsu_addr); end
    checks++; if (bus.lsu_width !== WIDTH_8) begin errors++; $display("FAIL wr_p2_width: got %b exp 1", bus.lsu_width); end
    checks++; if (bus.lsu_cmd !== CMD_READ) begin errors++; $display("FAIL wr_p2_cmd: got %b exp 0", bus.lsu_cmd); end
    checks++; if (bus.cpl_port !== PORT_FETCH) begin errors++; $display("FAIL wr_c1_port: got %b exp 1", bus.cpl_port); end
    checks++; if (bus.cpl_last !== 1'b0) begin errors++; $display("FAIL wr_c1_last: got %b exp 0", bus.cpl_last); end
    tick(); settle();
    checks++; if (bus.cpl_valid !== 1'b1) begin errors++; $display("FAIL wr_c2_valid: got %b exp 1", bus.cpl_valid); end
    checks++; if (bus.cpl_port !== PORT_FETCH) begin errors++; $display("FAIL wr_c2_port: got %b exp 1", bus.cpl_port); end
    checks++; if (bus.cpl_last !== 1'b1) begin errors++; $display("FAIL wr_c2_last: got %b exp 1", bus.cpl_last); end
    checks++; if (bus.f_ready !== 1'b1) begin errors++; $display("FAIL wr_f_ready: got %b exp 1", bus.f_ready); end
    tick();
    bus.mem_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_addr [6];
    logic        exp_cmd  [6];
    exp_addr = '{16'h3001, 16'h3002, 16'h4000, 16'h3001, 16'h3002, 16'h4000};
    exp_cmd  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tick();
    bus.d_addr = 16'h3001; bus.d_data = 16'hA55A; bus.d_width = WIDTH_16;
    bus.d_cmd = CMD_WRITE; bus.d_tag = 2'd3; bus.d_valid = 1'b1;
    bus.f_addr = 16'h4000; bus.f_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) begin bus.d_valid = 1'b0; bus.f_valid = 1'b0; end
      settle();
      checks++; if (bus.lsu_start !== 1'b1) begin errors++; $display("FAIL b2b_start[%0d]: got %b exp 1", i, bus.lsu_start); end
      checks++; if (bus.lsu_addr !== exp_addr[i]) begin errors++; $display("FAIL b2b_addr[%0d]: got %h exp %h", i, bus.lsu_addr, exp_addr[i]); end
      checks++; if (bus.lsu_cmd !== exp_cmd[i]) begin errors++; $display("FAIL b2b_cmd[%0d]: got %b exp %b", i, bus.lsu_cmd, exp_cmd[i]); end
      if (i == 1) begin
        checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_reload: got %b exp 0", bus.d_ready); end
        checks++; if (bus.lsu_data !== 16'hA5A5) begin errors++; $display("FAIL b2b_p2_data: got %h exp a5a5", bus.lsu_data); end
      end
    end
    tick();
    bus.mem_rdy = 1'b1; settle();
    checks++; if (bus.lsu_start !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b exp 0", bus.lsu_start); end
    checks++; if (bus.cpl_port !== PORT_FETCH) begin errors++; $display("FAIL b2b_cpl_port: got %b exp 1", bus.cpl_port); end
    checks++; if (bus.cpl_last !== 1'b1) begin errors++; $display("FAIL b2b_cpl_last: got %b exp 1", bus.cpl_last); end
    tick();
    bus.mem_rdy = 1'b0;
  endtask

  task automatic test_hold();
    tick();
    bus.lsu_hold = 1'b1;
    bus.d_addr = 16'h5000; bus.d_data = 16'h0F0F; bus.d_width = WIDTH_16;
    bus.d_cmd = CMD_WRITE; bus.d_tag = 2'd1; bus.d_valid = 1'b1;
    bus.f_addr = 16'h6000; bus.f_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin bus.d_valid = 1'b0; bus.f_valid = 1'b0; bus.mem_rdy = 1'b1; end
      settle();
      checks++; if (bus.lsu_start !== 1'b1) begin errors++; $display("FAIL hold_start[%0d]: got %b exp 1", i, bus.lsu_start); end
      checks++; if (bus.lsu_addr !== 16'h5000) begin errors++; $display("FAIL hold_addr[%0d]: got %h exp 5000", i, bus.lsu_addr); end
      checks++; if (bus.lsu_data !== 16'h0F0F) begin errors++; $display("FAIL hold_data[%0d]: got %h exp 0f0f", i, bus.lsu_data); end
      checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL hold_d_ready[%0d]: got %b exp 0", i, bus.d_ready); end
      checks++; if (bus.f_ready !== 1'b0) begin errors++; $display("FAIL hold_f_ready[%0d]: got %b exp 0", i, bus.f_ready); end
      checks++; if (bus.cpl_valid !== 1'b0) begin errors++; $display("FAIL hold_no_issue[%0d]: got %b exp 0", i, bus.cpl_valid); end
    end
    tick();
    bus.lsu_hold = 1'b0; bus.mem_rdy = 1'b0; settle();
    checks++; if (bus.lsu_addr !== 16'h5000) begin errors++; $display("FAIL hold_release_addr: got %h exp 5000", bus.lsu_addr); end
    tick(); settle();
    checks++; if (bus.lsu_addr !== 16'h6000) begin errors++; $display("FAIL hold_next_addr: got %h exp 6000", bus.lsu_addr); end
    checks++; if (bus.lsu_cmd !== CMD_READ) begin errors++; $display("FAIL hold_next_cmd: got %b exp 0", bus.lsu_cmd); end
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL hold_d_freed: got %b exp 1", bus.d_ready); end
    tick(); settle();
    checks++; if (bus.lsu_start !== 1'b0) begin errors++; $display("FAIL hold_drained: got %b exp 0", bus.lsu_start); end
    bus.mem_rdy = 1'b1;
    tick();
    bus.mem_rdy = 1'b0;
  endtask

  task automatic test_reset_split();
    tick();
    bus.d_addr = 16'h7001; bus.d_data = 16'h1122; bus.d_width = WIDTH_16;
    bus.d_cmd = CMD_READ; bus.d_tag = 2'd2; bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    tick(); settle();
    checks++; if (bus.lsu_addr !== 16'h7002) begin errors++; $display("FAIL rs_pending_addr: got %h exp 7002", bus.lsu_addr); end
    a_rst = 1'b0; bus.mem_rdy = 1'b1; settle();
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL rs_d_ready: got %b exp 1", bus.d_ready); end
    checks++; if (bus.f_ready !== 1'b1) begin errors++; $display("FAIL rs_f_ready: got %b exp 1", bus.f_ready); end
    checks++; if (bus.lsu_start !== 1'b0) begin errors++; $display("FAIL rs_start: got %b exp 0", bus.lsu_start); end
    checks++; if (bus.cpl_valid !== 1'b0) begin errors++; $display("FAIL rs_cpl_valid: got %b exp 0", bus.cpl_valid); end
    #1 a_rst = 1'b1;
    tick(); settle();
    checks++; if (bus.lsu_start !== 1'b0) begin errors++; $display("FAIL rs_p2_discarded: got %b exp 0", bus.lsu_start); end
    checks++; if (bus.cpl_valid !== 1'b0) begin errors++; $display("FAIL rs_no_cpl: got %b exp 0", bus.cpl_valid); end
    bus.mem_rdy = 1'b0;
  endtask

  initial begin
    bus.d_addr = '0; bus.d_data = '0; bus.d_width = 1'b0; bus.d_cmd = 1'b0;
    bus.d_tag = '0; bus.d_valid = 1'b0; bus.f_addr = '0; bus.f_valid = 1'b0;
    bus.lsu_hold = 1'b0; bus.mem_rdy = 1'b0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_wrap();
    test_back_to_back();
    test_hold();
    test_reset_split();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
